// File: rtl/ysyx_220066_mem_pkg.sv
// Shared types and constants for the data-memory responder and its byte-writable array.
package ysyx_220066_mem_pkg;

    localparam int XLEN  = 64;
    localparam int MASKW = 8;
    localparam logic [XLEN-1:0] BASE_ADDR_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_w,
                                                    input logic [XLEN-1:0] new_w,
                                                    input logic [MASKW-1:0] mask);
        logic [XLEN-1:0] r;
        r = old_w;
        for (int i = 0; i < MASKW; i++) begin
            if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ysyx_220066_sram_bytewr.sv
// Synchronous single-port word array with byte-lane write merge and a registered read port.
module ysyx_220066_sram_bytewr
    import ysyx_220066_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [XLEN-1:0]       wdata,
    input  logic [MASKW-1:0]      wmask,
    output logic [XLEN-1:0]       rdata
);

    logic [XLEN-1:0] mem_q [2**DEPTH_LOG2];

    // Read returns the pre-write contents; the responder drives 0 for writes anyway.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem_q[idx] <= merge_bytes(mem_q[idx], wdata, wmask);
            rdata <= mem_q[idx];
        end
    end

endmodule

// File: rtl/ysyx_220066_dmem_responder.sv
// Fixed-latency memory responder: one outstanding request, served from an on-chip array.
module ysyx_220066_dmem_responder
    import ysyx_220066_mem_pkg::*;
#(
    parameter int              DEPTH_LOG2 = 10,
    parameter int              LATENCY    = 2,
    parameter logic [XLEN-1:0] BASE_ADDR  = BASE_ADDR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_addr,
    input  logic             req_wen,
    input  logic [XLEN-1:0]  req_wdata,
    input  logic [MASKW-1:0] req_wmask,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_error,
    output state_e           dbg_state
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    // Handshake: a request transfers on an edge where req_valid && req_ready, a response on an
    // edge where resp_valid && resp_ready; valid never depends on the matching ready.
    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    wen_q;
    logic [XLEN-1:0]         wdata_q;
    logic [MASKW-1:0]        wmask_q;
    logic                    err_q;
    logic                    rd_q;
    logic                    resp_err_q;

    logic [XLEN-1:0]         off_d;
    logic [DEPTH_LOG2-1:0]   idx_d;
    logic                    err_d;
    logic                    sram_en;
    logic [XLEN-1:0]         sram_rdata;
    logic                    unused_off_bits;

    // Wrap-around subtraction folds addresses below the base into the out-of-range check.
    always_comb begin
        off_d           = req_addr - BASE_ADDR;
        idx_d           = off_d[DEPTH_LOG2+2:3];
        err_d           = |off_d[XLEN-1:DEPTH_LOG2+3];
        unused_off_bits = ^off_d[2:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            err_q      <= 1'b0;
            rd_q       <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q <= BUSY;
                        cnt_q   <= LAT_M1;
                        idx_q   <= idx_d;
                        wen_q   <= req_wen;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        err_q   <= err_d;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= RESP;
                        resp_err_q <= err_q;
                        rd_q       <= !wen_q && !err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q    <= IDLE;
                        rd_q       <= 1'b0;
                        resp_err_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The array is touched only on the final BUSY cycle, so a reset before then drops the access.
    assign sram_en = (state_q == BUSY) && (cnt_q == 4'd0) && !err_q;

    ysyx_220066_sram_bytewr #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (wen_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .wmask (wmask_q),
        .rdata (sram_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_error = resp_err_q;
    assign resp_rdata = rd_q ? sram_rdata : '0;
    assign dbg_state  = state_q;

endmodule
